// File: rtl/exception_step4_pkg.sv
// Shared definitions for the stage-4 exception/interrupt commit unit:
// cause codes, state encoding and datapath widths.
package exception_step4_pkg;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned CAUSE_W = 3;

   typedef enum logic [CAUSE_W-1:0] {
      CAUSE_EXT     = 3'b000,
      CAUSE_ILLEGAL = 3'b001,
      CAUSE_OVF     = 3'b010,
      CAUSE_SYSCALL = 3'b011,
      CAUSE_NONE    = 3'b100
   } cause_e;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_TAKE    = 2'd1,
      ST_HANDLER = 2'd2,
      ST_RETURN  = 2'd3
   } state_e;

endpackage

// File: rtl/exception_step4_irq_sync_edge.sv
// External interrupt front end: 2-flop synchroniser, rising-edge detect and
// a pending latch that holds one request until cleared (extra edges absorbed).
module exception_step4_irq_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   input  logic clear,
   output logic pending
);

   logic sync_q1;
   logic sync_q2;
   logic prev_q;
   logic rise_c;

   assign rise_c = sync_q2 & ~prev_q;

   // Clear wins over a coincident edge: that edge lands on an already-pending request.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         prev_q  <= 1'b0;
         pending <= 1'b0;
      end else begin
         sync_q1 <= irq;
         sync_q2 <= sync_q1;
         prev_q  <= sync_q2;
         if (clear) begin
            pending <= 1'b0;
         end else if (rise_c) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/exception_step4.sv
// Stage-4 exception/interrupt commit unit: captures cause and EPC, sequences
// handler entry/return and drives the one-cycle pipeline redirect.
// Optional saturating exception counter on output exc_count when EXC_STATS_EN is defined.
module exception_step4
   import exception_step4_pkg::*;
#(
   parameter logic [ADDR_W-1:0] VEC_EXT     = 16'd4,
   parameter logic [ADDR_W-1:0] VEC_ILLEGAL = 16'd8,
   parameter logic [ADDR_W-1:0] VEC_OVF     = 16'd12,
   parameter logic [ADDR_W-1:0] VEC_SYSCALL = 16'd16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CAUSE_W-1:0]  cause_step3,
   input  logic                valid_step3,
   input  logic [ADDR_W-1:0]   pc_step3,
   input  logic                eret_step3,
   input  logic                ext_irq,
   output logic [CAUSE_W-1:0]  cause_step4,
   output logic                interrupts_signal,
   output logic [ADDR_W-1:0]   interrupts_addr,
   output logic [ADDR_W-1:0]   epc,
   output logic                status_ie,
   output logic                in_handler,
   output logic                double_fault
`ifdef EXC_STATS_EN
   ,
   output logic [7:0]          exc_count
`endif
);

   state_e state;
   logic   ext_pending;
   logic   exc_c;
   logic   ext_take_c;

   function automatic logic [ADDR_W-1:0] vector_of(input logic [CAUSE_W-1:0] cause);
      case (cause)
         CAUSE_EXT:     vector_of = VEC_EXT;
         CAUSE_ILLEGAL: vector_of = VEC_ILLEGAL;
         CAUSE_OVF:     vector_of = VEC_OVF;
         CAUSE_SYSCALL: vector_of = VEC_SYSCALL;
         default:       vector_of = VEC_ILLEGAL;
      endcase
   endfunction

   assign exc_c      = valid_step3 && (cause_step3 != CAUSE_NONE);
   // External requests only attach to a real instruction so EPC is always meaningful.
   assign ext_take_c = (state == ST_RUN) && !exc_c && ext_pending && status_ie && valid_step3;

   exception_step4_irq_sync_edge u_irq (
      .clk     (clk),
      .reset   (reset),
      .irq     (ext_irq),
      .clear   (ext_take_c),
      .pending (ext_pending)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state             <= ST_RUN;
         cause_step4       <= CAUSE_NONE;
         interrupts_signal <= 1'b0;
         interrupts_addr   <= '0;
         epc               <= '0;
         status_ie         <= 1'b1;
         in_handler        <= 1'b0;
         double_fault      <= 1'b0;
      end else begin
         interrupts_signal <= 1'b0;
         interrupts_addr   <= '0;
         case (state)
            ST_RUN: begin
               cause_step4 <= valid_step3 ? cause_step3 : CAUSE_NONE;
               if (exc_c) begin
                  epc               <= (cause_step3 == CAUSE_SYSCALL) ? pc_step3 + 16'd1 : pc_step3;
                  interrupts_signal <= 1'b1;
                  interrupts_addr   <= vector_of(cause_step3);
                  state             <= ST_TAKE;
               end else if (ext_take_c) begin
                  epc               <= pc_step3;
                  cause_step4       <= CAUSE_EXT;
                  interrupts_signal <= 1'b1;
                  interrupts_addr   <= VEC_EXT;
                  state             <= ST_TAKE;
               end
            end
            ST_TAKE: begin
               status_ie   <= 1'b0;
               in_handler  <= 1'b1;
               cause_step4 <= CAUSE_NONE;
               state       <= ST_HANDLER;
            end
            ST_HANDLER: begin
               cause_step4 <= CAUSE_NONE;
               // A faulting instruction inside the handler is recorded, never re-entered.
               if (exc_c) begin
                  double_fault <= 1'b1;
               end else if (valid_step3 && eret_step3) begin
                  interrupts_signal <= 1'b1;
                  interrupts_addr   <= epc;
                  state             <= ST_RETURN;
               end
            end
            ST_RETURN: begin
               status_ie   <= 1'b1;
               in_handler  <= 1'b0;
               cause_step4 <= CAUSE_NONE;
               state       <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

`ifdef EXC_STATS_EN
   logic take_entry_c;

   assign take_entry_c = (state == ST_RUN) && (exc_c || ext_take_c);

   // Saturating count of handler entries.
   always_ff @(posedge clk) begin
      if (!reset) begin
         exc_count <= '0;
      end else if (take_entry_c && (exc_count != 8'hFF)) begin
         exc_count <= exc_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exception_step4.sv
// Randomised scoreboard bench for exception_step4 with a behavioural reference model.
module tb_exception_step4;
   import exception_step4_pkg::*;

   logic        clk;
   logic        reset;
   logic [2:0]  cause_step3;
   logic        valid_step3;
   logic [15:0] pc_step3;
   logic        eret_step3;
   logic        ext_irq;
   logic [2:0]  cause_step4;
   logic        interrupts_signal;
   logic [15:0] interrupts_addr;
   logic [15:0] epc;
   logic        status_ie;
   logic        in_handler;
   logic        double_fault;
`ifdef EXC_STATS_EN
   logic [7:0]  exc_count;
`endif

   exception_step4 dut (
      .clk               (clk),
      .reset             (reset),
      .cause_step3       (cause_step3),
      .valid_step3       (valid_step3),
      .pc_step3          (pc_step3),
      .eret_step3        (eret_step3),
      .ext_irq           (ext_irq),
      .cause_step4       (cause_step4),
      .interrupts_signal (interrupts_signal),
      .interrupts_addr   (interrupts_addr),
      .epc               (epc),
      .status_ie         (status_ie),
      .in_handler        (in_handler),
      .double_fault      (double_fault)
`ifdef EXC_STATS_EN
      ,
      .exc_count         (exc_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [2:0]  cause;
      logic [15:0] epc;
      logic        hand;
   } redir_t;

   redir_t sb[$];
   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   // Reference model: mode 0 running, 1 entering handler, 2 in handler, 3 leaving.
   int          m_mode;
   logic [2:0]  m_cause;
   logic [15:0] m_epc;
   bit          m_ie, m_hand, m_df, m_pend;
   bit          hx1, hx2, hx3;
   int          m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_cause = CAUSE_NONE; m_epc = 16'd0;
      m_ie = 1'b1; m_hand = 1'b0; m_df = 1'b0; m_pend = 1'b0;
      hx1 = 1'b0; hx2 = 1'b0; hx3 = 1'b0; m_cnt = 0;
   endtask

   task automatic check_status();
      chk("cause_step4", 32'(cause_step4), 32'(m_cause));
      chk("epc", 32'(epc), 32'(m_epc));
      chk("status_ie", 32'(status_ie), 32'(m_ie));
      chk("in_handler", 32'(in_handler), 32'(m_hand));
      chk("double_fault", 32'(double_fault), 32'(m_df));
`ifdef EXC_STATS_EN
      chk("exc_count", 32'(exc_count), 32'(m_cnt));
`endif
   endtask

   function automatic logic [15:0] vec(input logic [2:0] c);
      return 16'(4 * (int'(c) + 1));
   endfunction

   // One clock of stimulus: compare current outputs, drive, advance the model for the next edge.
   task automatic step(input bit r, input bit v, input logic [2:0] c, input logic [15:0] pc,
                       input bit er, input bit x);
      bit rise;
      redir_t e;
      @(negedge clk);
      check_status();
      reset = r; valid_step3 = v; cause_step3 = c; pc_step3 = pc; eret_step3 = er; ext_irq = x;
      if (!r) begin
         model_reset();
         return;
      end
      // A level rise seen two samples ago reaches the pending flag on this edge.
      rise = hx2 && !hx3;
      case (m_mode)
         0: begin
            m_cause = v ? c : 3'(CAUSE_NONE);
            if (v && c != CAUSE_NONE) begin
               m_epc = (c == CAUSE_SYSCALL) ? pc + 16'd1 : pc;
               if (rise) m_pend = 1'b1;
               e = '{vec(c), m_cause, m_epc, 1'b0};
               sb.push_back(e);
               m_mode = 1;
               if (m_cnt < 255) m_cnt++;
            end else if (m_pend && m_ie && v) begin
               m_epc = pc; m_cause = CAUSE_EXT; m_pend = 1'b0;
               e = '{16'd4, m_cause, m_epc, 1'b0};
               sb.push_back(e);
               m_mode = 1;
               if (m_cnt < 255) m_cnt++;
            end else if (rise) begin
               m_pend = 1'b1;
            end
         end
         1: begin
            m_ie = 1'b0; m_hand = 1'b1; m_cause = CAUSE_NONE; m_mode = 2;
            if (rise) m_pend = 1'b1;
         end
         2: begin
            m_cause = CAUSE_NONE;
            if (v && c != CAUSE_NONE) begin
               m_df = 1'b1;
            end else if (v && er) begin
               e = '{m_epc, 3'(CAUSE_NONE), m_epc, 1'b1};
               sb.push_back(e);
               m_mode = 3;
            end
            if (rise) m_pend = 1'b1;
         end
         default: begin
            m_ie = 1'b1; m_hand = 1'b0; m_cause = CAUSE_NONE; m_mode = 0;
            if (rise) m_pend = 1'b1;
         end
      endcase
      hx3 = hx2; hx2 = hx1; hx1 = x;
   endtask

   task automatic idle(input bit x);
      step(1'b1, 1'b0, CAUSE_NONE, 16'd0, 1'b0, x);
   endtask

   // Monitor: every redirect strobe must match the oldest expected redirect.
   initial begin
      redir_t e;
      forever begin
         @(posedge clk);
         #1;
         if (armed) begin
            if (interrupts_signal === 1'b1) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_redirect: got addr %0h expected no strobe at %0t",
                           interrupts_addr, $time);
               end else begin
                  e = sb.pop_front();
                  chk("redirect_addr", 32'(interrupts_addr), 32'(e.addr));
                  chk("redirect_cause", 32'(cause_step4), 32'(e.cause));
                  chk("redirect_epc", 32'(epc), 32'(e.epc));
                  chk("redirect_in_handler", 32'(in_handler), 32'(e.hand));
               end
            end else begin
               chk("idle_addr", 32'(interrupts_addr), 32'd0);
            end
         end
      end
   end

   initial begin
      bit found;
      reset = 1'b0; valid_step3 = 1'b0; cause_step3 = CAUSE_NONE; pc_step3 = 16'd0;
      eret_step3 = 1'b0; ext_irq = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      armed = 1'b1;

      // Overflow at 0x0040.
      step(1, 1, CAUSE_OVF, 16'h0040, 0, 0);
      idle(0);
      chk("ovf_strobe", 32'(interrupts_signal), 32'd1);
      chk("ovf_addr", 32'(interrupts_addr), 32'd12);
      idle(0);
      chk("ovf_epc", 32'(epc), 32'h0040);
      chk("ovf_in_handler", 32'(in_handler), 32'd1);
      chk("ovf_ie", 32'(status_ie), 32'd0);
      step(1, 1, CAUSE_NONE, 16'h0044, 1, 0);
      idle(0);
      chk("ovf_ret_addr", 32'(interrupts_addr), 32'h0040);
      idle(0);

      // Syscall at 0xFFFF wraps the return address.
      step(1, 1, CAUSE_SYSCALL, 16'hFFFF, 0, 0);
      idle(0);
      chk("sys_addr", 32'(interrupts_addr), 32'd16);
      chk("sys_epc", 32'(epc), 32'h0000);
      idle(0);
      step(1, 1, CAUSE_NONE, 16'h0020, 1, 0);
      idle(0);
      chk("sys_ret_strobe", 32'(interrupts_signal), 32'd1);
      chk("sys_ret_addr", 32'(interrupts_addr), 32'h0000);
      idle(0);
      chk("sys_ie_back", 32'(status_ie), 32'd1);

      // External interrupt with a stream of valid instructions at 0x0100.
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1, 1, CAUSE_NONE, 16'h0100, 0, 1);
         if (interrupts_signal === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk("ext_taken_in_time", 32'(found), 32'd1);
      chk("ext_addr", 32'(interrupts_addr), 32'd4);
      chk("ext_cause", 32'(cause_step4), 32'(CAUSE_EXT));
      chk("ext_epc", 32'(epc), 32'h0100);
      idle(0);
      step(1, 1, CAUSE_NONE, 16'h0004, 1, 0);
      idle(0);
      idle(0);

      // Pending external collides with an illegal instruction; illegal goes first.
      repeat (4) idle(1);
      step(1, 1, CAUSE_ILLEGAL, 16'h0200, 0, 0);
      idle(0);
      chk("sim_first_addr", 32'(interrupts_addr), 32'd8);
      idle(0);
      step(1, 1, CAUSE_NONE, 16'h0008, 1, 0);
      idle(0);
      chk("sim_ret_addr", 32'(interrupts_addr), 32'h0200);
      step(1, 1, CAUSE_NONE, 16'h0300, 0, 0);
      idle(0);
      chk("sim_ext_addr", 32'(interrupts_addr), 32'd4);
      chk("sim_ext_epc", 32'(epc), 32'h0300);
      idle(0);
      step(1, 1, CAUSE_NONE, 16'h0004, 1, 0);
      idle(0);
      idle(0);

      // Double fault inside the handler, then cleared by reset.
      step(1, 1, CAUSE_ILLEGAL, 16'h0010, 0, 0);
      idle(0);
      step(1, 1, CAUSE_OVF, 16'h0011, 0, 0);
      idle(0);
      chk("df_set", 32'(double_fault), 32'd1);
      chk("df_no_strobe", 32'(interrupts_signal), 32'd0);
      chk("df_cause_none", 32'(cause_step4), 32'(CAUSE_NONE));
      idle(0);
      chk("df_sticky", 32'(double_fault), 32'd1);
      step(0, 0, CAUSE_NONE, 16'd0, 0, 0);
      idle(0);
      chk("df_reset", 32'(double_fault), 32'd0);
      chk("df_reset_handler", 32'(in_handler), 32'd0);

`ifdef EXC_STATS_EN
      // Counter saturation.
      for (int i = 0; i < 300; i++) begin
         step(1, 1, CAUSE_OVF, 16'(i), 0, 0);
         idle(0);
         step(1, 1, CAUSE_NONE, 16'h000C, 1, 0);
         idle(0);
      end
      idle(0);
      chk("exc_count_sat", 32'(exc_count), 32'hFF);
`endif

      // Randomised traffic, including occasional resets and interrupt toggles.
      for (int i = 0; i < 3000; i++) begin
         bit          r, v, er, x;
         logic [2:0]  c;
         r  = ($urandom_range(0, 399) != 0);
         v  = ($urandom_range(0, 3) != 0);
         c  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'(CAUSE_NONE);
         er = ($urandom_range(0, 5) == 0);
         x  = ($urandom_range(0, 19) == 0) ? !ext_irq : ext_irq;
         step(r, v, c, 16'($urandom), er, x);
      end
      idle(0);
      idle(0);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exception_step4.md
Name: exception_step4

Overview:
- Stage-4 exception/interrupt commit unit.
- Registers the step-3 cause code into `cause_step4` and captures EPC.
- Synchronises the external interrupt line and sequences entry to and return from the handler.
- Drives the one-cycle `interrupts_signal` / `interrupts_addr` redirect that step 3 uses to flush the pipeline and select the PC source.

Parameters:
- VEC_EXT, 16'd4, handler address for external interrupt (cause 000)
- VEC_ILLEGAL, 16'd8, handler address for illegal instruction (cause 001)
- VEC_OVF, 16'd12, handler address for ALU overflow (cause 010)
- VEC_SYSCALL, 16'd16, handler address for syscall (cause 011)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- cause_step3  in  3  step-3 cause: 000 ext, 001 illegal, 010 overflow, 011 syscall, 100 none
- valid_step3  in  1  step 3 holds a real instruction (not a bubble or flushed slot)
- pc_step3  in  16  PC of the step-3 instruction
- eret_step3  in  1  step-3 instruction is return-from-exception
- ext_irq  in  1  asynchronous external interrupt request, level
- cause_step4  out  3  registered cause; 100 = none
- interrupts_signal  out  1  one-cycle redirect/flush strobe
- interrupts_addr  out  16  redirect target; valid while interrupts_signal=1, else 16'd0
- epc  out  16  saved return address
- status_ie  out  1  interrupt enable
- in_handler  out  1  handler currently executing
- double_fault  out  1  sticky; exception raised while in handler

Behaviour:
- Reset values: cause_step4=100, interrupts_signal=0, interrupts_addr=0, epc=0, status_ie=1, in_handler=0, double_fault=0. Synchroniser, edge detector and pending flag cleared; state=RUN.
- ext_irq path:
  - 2-flop synchroniser, then rising-edge detect.
  - An edge sets `ext_pending`; it stays set until taken.
  - An edge while pending is already set is absorbed (no queueing).
- States: RUN, TAKE, HANDLER, RETURN (2-bit encoding).
- RUN:
  - cause_step4 <= valid_step3 ? cause_step3 : 100.
  - Internal exception (valid_step3 and cause_step3!=100), taken regardless of status_ie:
    - epc <= pc_step3, or pc_step3+1 (16-bit wrap) for syscall 011.
    - Latched cause = cause_step3; go TAKE.
  - Otherwise, if ext_pending and status_ie and valid_step3:
    - epc <= pc_step3 (instruction re-executed); latched cause=000.
    - Clear ext_pending; cause_step4 <= 000; go TAKE.
  - Internal exception wins over a simultaneous external one; the external stays pending.
  - ext_pending with valid_step3=0 waits, so that EPC is always a real instruction.
- TAKE (exactly 1 cycle):
  - interrupts_signal=1; interrupts_addr=vector(latched cause).
  - Next edge: status_ie<=0, in_handler<=1, cause_step4<=100; go HANDLER.
- HANDLER:
  - cause_step4 forced to 100.
  - valid_step3 with cause_step3!=100: set double_fault, ignore the cause, stay in HANDLER.
  - ext edges still set ext_pending.
  - valid_step3 and eret_step3: go RETURN.
- RETURN (1 cycle):
  - interrupts_signal=1; interrupts_addr=epc.
  - Next edge: status_ie<=1, in_handler<=0; go RUN.
  - A pending external interrupt may be taken from the following cycle (earliest 2 cycles after eret_step3).
- Latency:
  - cause at step 3 → interrupts_signal high on the next cycle (1 cycle).
  - ext_irq rise → ext_pending set after 3 edges.
- interrupts_signal never asserts on two consecutive cycles.
- Reset mid-TAKE/RETURN: the redirect is abandoned and all state returns to reset values.

Optional Feature:
- Macro: EXC_STATS_EN.
- With EXC_STATS_EN defined:
  - Adds output exc_count[7:0], reset 0.
  - Increments on each TAKE entry; saturates at 8'hFF (no wrap).
- Without EXC_STATS_EN: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package/header:
  - Cause codes CAUSE_EXT=3'b000, CAUSE_ILLEGAL=3'b001, CAUSE_OVF=3'b010, CAUSE_SYSCALL=3'b011, CAUSE_NONE=3'b100.
  - State encodings RUN/TAKE/HANDLER/RETURN.
- One natural sub-module: irq_sync_edge. It holds the 2-flop synchroniser, rising-edge detector and pending latch, with a clear input.

Test Plan:
- Overflow: valid, cause_step3=010, pc_step3=16'h0040 → next cycle interrupts_signal=1, interrupts_addr=16'd12. Following cycle epc=16'h0040, in_handler=1, status_ie=0.
- Syscall at pc_step3=16'hFFFF → interrupts_addr=16'd16, epc=16'h0000 (wrap). eret_step3 later → RETURN cycle with interrupts_addr=16'h0000, status_ie back to 1.
- External: ext_irq rises while status_ie=1, pc_step3=16'h0100 with valid instructions → TAKE ≤4 cycles later, interrupts_addr=16'd4, cause_step4=000, epc=16'h0100.
- Simultaneous: ext_pending set while cause_step3=001 → vector 16'd8 taken first. After eret and RETURN, the external is taken with vector 16'd4.
- In HANDLER, cause_step3=010 valid → double_fault=1 sticky, no interrupts_signal, cause_step4=100; reset=0 for one edge → double_fault=0, state RUN.
- EXC_STATS_EN defined: 300 forced exceptions → exc_count=8'hFF.
